// File: rtl/uart_frame_check.sv
// Post-data frame checker for the UART RX path: validates the optional parity
// bit and one or two stop bits, flags breaks and counts erroneous frames.
module uart_frame_check #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chk_start,
  input  logic                      chk_abort,
  input  logic                      par_en,
  input  logic                      par_type,
  input  logic                      two_stop,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      sampled_bit,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic                      err_cnt_clr,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      brk_det,
  output logic                      chk_done,
  output logic                      frame_valid,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, PARITY, STOP1, STOP2, DONE} state_e;

  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE  = 1;
  localparam logic [ERR_CNT_WIDTH-1:0]  CNT_ONE = 1;

  state_e                    state_q;
  logic                      par_en_q, par_type_q, two_stop_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_bit_q;
  logic                      par_err_q, stp_err_q, brk_det_q;
  logic                      chk_done_q, frame_valid_q;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;

  logic mid_pt, bit_end, data_zero, cnt_sat, frame_bad;

  assign mid_pt    = (edge_cnt == (Prescale >> 1));
  assign bit_end   = (edge_cnt == (Prescale - PS_ONE));
  assign data_zero = (data_q == '0);
  assign cnt_sat   = &err_cnt_q;
  assign frame_bad = par_err_q | stp_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      par_en_q      <= 1'b0;
      par_type_q    <= 1'b0;
      two_stop_q    <= 1'b0;
      data_q        <= '0;
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      brk_det_q     <= 1'b0;
      chk_done_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      chk_done_q    <= 1'b0;
      frame_valid_q <= 1'b0;

      // An abort that lands in DONE also suppresses that frame's count.
      if (err_cnt_clr)
        err_cnt_q <= '0;
      else if (state_q == DONE && !chk_abort && frame_bad && !cnt_sat)
        err_cnt_q <= err_cnt_q + CNT_ONE;

      if (chk_abort && state_q != IDLE) begin
        state_q   <= IDLE;
        par_err_q <= 1'b0;
        stp_err_q <= 1'b0;
        brk_det_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (chk_start && !chk_abort) begin
              par_en_q   <= par_en;
              par_type_q <= par_type;
              two_stop_q <= two_stop;
              data_q     <= data;
              par_bit_q  <= 1'b0;
              par_err_q  <= 1'b0;
              stp_err_q  <= 1'b0;
              brk_det_q  <= 1'b0;
              state_q    <= par_en ? PARITY : STOP1;
            end
          end
          PARITY: begin
            if (mid_pt) begin
              par_err_q <= sampled_bit ^ (^data_q) ^ par_type_q;
              par_bit_q <= sampled_bit;
            end
            if (bit_end) state_q <= STOP1;
          end
          STOP1: begin
            if (mid_pt) begin
              stp_err_q <= stp_err_q | ~sampled_bit;
              brk_det_q <= data_zero & ~sampled_bit & (~par_en_q | ~par_bit_q);
              if (!two_stop_q) begin
                state_q       <= DONE;
                chk_done_q    <= 1'b1;
                frame_valid_q <= ~(par_err_q | stp_err_q | ~sampled_bit);
              end
            end else if (bit_end && two_stop_q) begin
              state_q <= STOP2;
            end
          end
          STOP2: begin
            if (mid_pt) begin
              stp_err_q     <= stp_err_q | ~sampled_bit;
              state_q       <= DONE;
              chk_done_q    <= 1'b1;
              frame_valid_q <= ~(par_err_q | stp_err_q | ~sampled_bit);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign brk_det     = brk_det_q;
  assign chk_done    = chk_done_q;
  assign frame_valid = frame_valid_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: directed frames with literal expectations, then
// randomized frames against a frame-level reference model.
module tb_uart_frame_check;
  localparam int PW = 6;
  localparam int DW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          chk_start, chk_abort, par_en, par_type, two_stop;
  logic          sampled_bit, err_cnt_clr;
  logic [DW-1:0] data;
  logic [PW-1:0] Prescale, edge_cnt;
  logic          par_err, stp_err, brk_det, chk_done, frame_valid;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // model state: held flags {brk,stp,par}, error count, DONE tracking
  bit [2:0] m_flags;
  int       m_cnt;
  bit       m_in_done, m_done_err;
  bit       rand_clr;
  int       seen_done_j;

  always #5 clk = ~clk;

  uart_frame_check #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .chk_start(chk_start), .chk_abort(chk_abort),
    .par_en(par_en), .par_type(par_type), .two_stop(two_stop), .data(data),
    .sampled_bit(sampled_bit), .Prescale(Prescale), .edge_cnt(edge_cnt),
    .err_cnt_clr(err_cnt_clr), .par_err(par_err), .stp_err(stp_err),
    .brk_det(brk_det), .chk_done(chk_done), .frame_valid(frame_valid),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, clock, update model, compare #1 after the edge.
  task automatic cyc(input bit st, input bit ab, input bit sb, input int ec, input bit fclr,
                     input bit exp_done, input bit exp_fv, input bit flags_ok);
    bit clr;
    clr = fclr || (rand_clr && $urandom_range(15) == 0);
    chk_start = st; chk_abort = ab; sampled_bit = sb; edge_cnt = ec[PW-1:0]; err_cnt_clr = clr;
    @(posedge clk);
    if (clr) m_cnt = 0;
    else if (m_in_done && !ab && m_done_err && m_cnt < 255) m_cnt++;
    m_in_done  = exp_done;
    m_done_err = m_flags[0] | m_flags[1];
    #1;
    chk("chk_done", chk_done, exp_done);
    chk("frame_valid", frame_valid, exp_done & exp_fv);
    chk("err_cnt", err_cnt, m_cnt);
    if (flags_ok) begin
      chk("par_err", par_err, m_flags[0]);
      chk("stp_err", stp_err, m_flags[1]);
      chk("brk_det", brk_det, m_flags[2]);
    end
    chk_start = 0; chk_abort = 0; err_cnt_clr = 0;
  endtask

  // abort_sel: -1 none, 0 abort together with start, >0 abort at that cycle, -2 random
  task automatic frame(input int P, input bit pe, input bit pt, input bit ts, input logic [7:0] d,
                       input bit pbit, input bit s1, input bit s2, input int abort_sel,
                       input bit noise, input bit clr_at_done);
    int nb, mid, done_j, total, stray_j, abort_j, bi, ec, idx;
    bit pb[3];
    bit e_par, e_stp, e_brk, st, ab, sb, dn, fok, fc;
    nb  = 1 + int'(pe) + int'(ts);
    idx = 0;
    if (pe) begin pb[idx] = pbit; idx++; end
    pb[idx] = s1; idx++;
    if (ts) pb[idx] = s2;
    mid    = P / 2;
    done_j = 1 + (nb - 1) * P + mid;
    abort_j = abort_sel;
    if (abort_sel == -2)
      abort_j = ($urandom_range(5) == 0) ? int'($urandom_range(done_j)) : -1;
    e_par = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
    e_stp = !s1 || (ts && !s2);
    e_brk = (d == 0) && !s1 && (!pe || !pbit);
    Prescale = P[PW-1:0]; par_en = pe; par_type = pt; two_stop = ts; data = d;
    total   = nb * P + 2 + int'($urandom_range(3));
    stray_j = 1 + int'($urandom_range(done_j - 1));
    seen_done_j = -1;
    for (int j = 0; j < total; j++) begin
      st = 0; ab = 0; dn = 0; fok = 0; fc = 0;
      ec = (j == 0) ? P - 1 : (j - 1) % P;
      bi = (j - 1) / P;
      if (j >= 1 && j <= nb * P)
        sb = (noise && ec != mid) ? bit'($urandom_range(1)) : pb[bi];
      else
        sb = noise ? bit'($urandom_range(1)) : 1'b1;
      if (j == 0) st = 1;
      if (noise && j == stray_j && (abort_j < 0 || j < abort_j)) st = 1;
      if (j == abort_j) ab = 1;
      if (j == 1) begin
        par_en = bit'($urandom_range(1)); par_type = bit'($urandom_range(1));
        two_stop = bit'($urandom_range(1)); data = 8'($urandom);
      end
      if (clr_at_done && j == done_j + 1) fc = 1;
      if (abort_j == 0) fok = 1;
      else if (abort_j > 0 && j >= abort_j) begin m_flags = 3'b000; fok = 1; end
      else if (j == 0) begin m_flags = 3'b000; fok = 1; end
      else if (abort_j < 0 && j == done_j) begin m_flags = {e_brk, e_stp, e_par}; dn = 1; fok = 1; end
      else if (abort_j < 0 && j > done_j) fok = 1;
      cyc(st, ab, sb, ec, fc, dn, !(e_par || e_stp), fok);
      if (chk_done === 1'b1) seen_done_j = j;
    end
  endtask

  initial begin
    reset = 1; chk_start = 0; chk_abort = 0; par_en = 0; par_type = 0; two_stop = 0;
    data = '0; sampled_bit = 1; Prescale = 6'd8; edge_cnt = '0; err_cnt_clr = 0;
    rand_clr = 0; m_flags = 0; m_cnt = 0; m_in_done = 0; m_done_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chk_done", chk_done, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_flags", {brk_det, stp_err, par_err}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, 0, 0, 0, 1);

    // clean 8N1 frame: done 5 clocks after start (mid-point edge_cnt==4)
    frame(8, 0, 0, 0, 8'h5A, 0, 1, 1, -1, 0, 0);
    chk("t1_latency", seen_done_j, 5);
    chk("t1_err_cnt", err_cnt, 0);

    // A5 has four ones; even parity with parity bit 1 is wrong
    frame(8, 1, 0, 0, 8'hA5, 1, 1, 1, -1, 0, 0);
    chk("t2_par_err", par_err, 1);
    chk("t2_err_cnt", err_cnt, 1);

    // two stop bits, second one low: done at STOP2 mid-point
    frame(8, 0, 0, 1, 8'h33, 0, 1, 0, -1, 0, 0);
    chk("t3_latency", seen_done_j, 13);
    chk("t3_stp_err", stp_err, 1);
    chk("t3_err_cnt", err_cnt, 2);

    // break
    frame(8, 0, 0, 0, 8'h00, 0, 0, 1, -1, 0, 0);
    chk("t4_brk", {brk_det, stp_err}, 2'b11);
    chk("t4_err_cnt", err_cnt, 3);

    // start and abort together in IDLE: no frame, flags held
    frame(8, 0, 0, 0, 8'h12, 0, 0, 1, 0, 0, 0);
    chk("t5_no_done", seen_done_j, -1);
    chk("t5_flags_held", {brk_det, stp_err}, 2'b11);

    // abort during PARITY
    frame(8, 1, 1, 0, 8'h0F, 0, 1, 1, 3, 0, 0);
    chk("t6_no_done", seen_done_j, -1);
    chk("t6_flags", {brk_det, stp_err, par_err}, 0);
    chk("t6_err_cnt", err_cnt, 3);

    // clear coincident with increment
    frame(8, 0, 0, 0, 8'h77, 0, 0, 1, -1, 0, 1);
    chk("t7_clr_wins", err_cnt, 0);

    // saturation
    for (int i = 0; i < 258; i++) frame(4, 0, 0, 0, 8'h00, 0, 0, 1, -1, 0, 0);
    chk("t8_sat", err_cnt, 8'hFF);
    frame(4, 1, 0, 0, 8'h00, 0, 0, 1, -1, 0, 0);
    chk("t8_sat_hold", err_cnt, 8'hFF);

    // reset mid-frame
    Prescale = 6'd8; par_en = 0; par_type = 0; two_stop = 0; data = 8'h3C;
    cyc(1, 0, 1, 7, 0, 0, 0, 0);
    for (int j = 1; j < 4; j++) cyc(0, 0, 0, j - 1, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    chk("rst_mid_err_cnt", err_cnt, 0);
    chk("rst_mid_flags", {chk_done, frame_valid, brk_det, stp_err, par_err}, 0);
    @(posedge clk);
    #1 reset = 0;
    m_cnt = 0; m_flags = 0; m_in_done = 0; m_done_err = 0;
    for (int j = 0; j < 12; j++) cyc(0, 0, 0, (j + 4) % 8, 0, 0, 0, 1);

    // randomized frames
    rand_clr = 1;
    for (int i = 0; i < 150; i++) begin
      int P;
      bit pe, pt, ts, pbit, s1, s2;
      logic [7:0] d;
      P  = int'($urandom_range(16, 4));
      pe = bit'($urandom_range(1)); pt = bit'($urandom_range(1)); ts = bit'($urandom_range(1));
      d  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      pbit = bit'($urandom_range(1));
      s1 = ($urandom_range(3) != 0);
      s2 = ($urandom_range(3) != 0);
      frame(P, pe, pt, ts, d, pbit, s1, s2, -2, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
